// File: rtl/btpipe_pkg.sv
// btpipe_pkg
// Shared definitions for the block-throttled pipe input buffer.
// Holds the default geometry constants and the encoding of the block
// framing FSM, so that the buffer and any neighbour logic agree on them.
package btpipe_pkg;

    // Default geometry: 16-bit words, 256-word buffer, 64-word host blocks.
    // The buffer depth must be a power of two and hold at least two blocks.
    localparam int DEFAULT_WIDTH     = 16;
    localparam int DEFAULT_DEPTH     = 256;
    localparam int DEFAULT_BLOCK_LEN = 64;

    // Block framing state: IDLE waits for a block strobe, RECV counts the
    // words of the block currently being transferred by the host.
    typedef enum logic [0:0] {
        BLK_IDLE = 1'b0,
        BLK_RECV = 1'b1
    } block_state_e;

endpackage

// File: rtl/sdp_ram.sv
// sdp_ram
// Simple dual-port storage array: one write port, one read port with a
// registered read, both on the same clock. The array itself has no reset;
// its contents are only meaningful once written.
//
// Ports:
//   clock    sole clock
//   wr_en    write strobe
//   wr_addr  write address
//   wr_data  write data
//   rd_en    read strobe; rd_data updates only on edges where it is high
//   rd_addr  read address
//   rd_data  registered read data, held while rd_en is low
module sdp_ram #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 256
) (
    input  logic                     clock,
    input  logic                     wr_en,
    input  logic [$clog2(DEPTH)-1:0] wr_addr,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     rd_en,
    input  logic [$clog2(DEPTH)-1:0] rd_addr,
    output logic [WIDTH-1:0]         rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Write port.
    always_ff @(posedge clock) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Read port. Holding rd_data while rd_en is low lets the owner use this
    // register directly as a stall-stable output stage.
    always_ff @(posedge clock) begin
        if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/btpipe_in_buffer.sv
// btpipe_in_buffer
// Input buffer for a block-throttled host pipe. The host writes words in
// blocks of BLOCK_LEN, each announced by a one-cycle block strobe, and only
// starts a block while ep_ready says a whole block fits. Words are handed to
// the consumer first-word-fall-through with a valid/ready handshake.
//
// Ports:
//   clock           sole clock
//   reset           asynchronous active-high reset
//   clear           synchronous flush of buffer, flags and block FSM
//   ep_write        host write strobe, one word per cycle
//   ep_blockstrobe  one-cycle pulse ahead of each host block
//   ep_datain       host write data
//   ep_ready        registered: room for at least one full block
//   data_out        head word to the consumer (zero while data_valid is low)
//   data_valid      data_out holds a valid word
//   data_ready      consumer takes the head word when data_valid is high
//   fill_level      words held, including the head word
//   overflow        sticky: a host write was dropped because the buffer was full
//   short_block     sticky: a block was cut short by the next block strobe
module btpipe_in_buffer
    import btpipe_pkg::*;
#(
    parameter int WIDTH     = DEFAULT_WIDTH,
    parameter int DEPTH     = DEFAULT_DEPTH,
    parameter int BLOCK_LEN = DEFAULT_BLOCK_LEN
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   clear,
    input  logic                   ep_write,
    input  logic                   ep_blockstrobe,
    input  logic [WIDTH-1:0]       ep_datain,
    output logic                   ep_ready,
    output logic [WIDTH-1:0]       data_out,
    output logic                   data_valid,
    input  logic                   data_ready,
    output logic [$clog2(DEPTH):0] fill_level,
    output logic                   overflow,
    output logic                   short_block
);

    localparam int AW = $clog2(DEPTH);
    localparam int FW = AW + 1;
    localparam int CW = $clog2(BLOCK_LEN + 1);

    localparam logic [FW-1:0] DEPTH_F = FW'(DEPTH);
    localparam logic [FW-1:0] BLOCK_F = FW'(BLOCK_LEN);
    localparam logic [CW-1:0] BLOCK_C = CW'(BLOCK_LEN);

    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [FW-1:0]    fill_next;
    logic [WIDTH-1:0] ram_rd_data;
    logic             full;
    logic             push;
    logic             pop;
    logic             ram_has_word;
    logic             rd_en;

    block_state_e     blk_state;
    logic [CW-1:0]    blk_count;

    // The RAM read register doubles as the head register. A word written on
    // one edge becomes readable in the array on the next, so it reaches
    // data_out one edge after it was written. Words still in the array are
    // fill_level minus the head word. Fullness is judged on the registered
    // level, so a write into a full buffer is dropped even when the consumer
    // pops on the same edge.
    always_comb begin
        full         = (fill_level == DEPTH_F);
        push         = ep_write && !full && !clear;
        pop          = data_valid && data_ready;
        ram_has_word = ((fill_level - FW'(data_valid)) != '0);
        rd_en        = ram_has_word && (!data_valid || data_ready) && !clear;
        fill_next    = fill_level + FW'(push) - FW'(pop);
    end

    sdp_ram #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_ram (
        .clock   (clock),
        .wr_en   (push),
        .wr_addr (wr_ptr),
        .wr_data (ep_datain),
        .rd_en   (rd_en),
        .rd_addr (rd_ptr),
        .rd_data (ram_rd_data)
    );

    // The array output is not reset, so it is masked until a word is valid;
    // this also makes data_out read zero during and right after reset.
    assign data_out = data_valid ? ram_rd_data : '0;

    // Pointers, fill level, head-valid flag, overflow and ep_ready. Both
    // pointers are AW bits wide so they wrap modulo DEPTH on their own.
    // ep_ready reflects the level after this edge's push and pop.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fill_level <= '0;
            data_valid <= 1'b0;
            overflow   <= 1'b0;
            ep_ready   <= 1'b0;
        end else if (clear) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fill_level <= '0;
            data_valid <= 1'b0;
            overflow   <= 1'b0;
            // An empty buffer always has room for a block.
            ep_ready   <= 1'b1;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (rd_en) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            fill_level <= fill_next;
            if (rd_en) begin
                data_valid <= 1'b1;
            end else if (pop) begin
                data_valid <= 1'b0;
            end
            if (ep_write && full) begin
                overflow <= 1'b1;
            end
            ep_ready <= ((DEPTH_F - fill_next) >= BLOCK_F);
        end
    end

    // Block framing FSM. A strobe opens a block with a cleared count; every
    // host write cycle inside the block counts, dropped or not. A strobe that
    // arrives before the count reaches BLOCK_LEN flags a short block and
    // opens the next one. The count saturates at BLOCK_LEN on block end.
    // Writes seen in IDLE are stored but not framed.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            blk_state   <= BLK_IDLE;
            blk_count   <= '0;
            short_block <= 1'b0;
        end else if (clear) begin
            blk_state   <= BLK_IDLE;
            blk_count   <= '0;
            short_block <= 1'b0;
        end else begin
            unique case (blk_state)
                BLK_IDLE: begin
                    if (ep_blockstrobe) begin
                        blk_state <= BLK_RECV;
                        blk_count <= '0;
                    end
                end
                BLK_RECV: begin
                    if (ep_blockstrobe) begin
                        if (blk_count < BLOCK_C) begin
                            short_block <= 1'b1;
                        end
                        blk_count <= '0;
                    end else if (ep_write) begin
                        if (blk_count >= BLOCK_C - CW'(1)) begin
                            blk_count <= BLOCK_C;
                            blk_state <= BLK_IDLE;
                        end else begin
                            blk_count <= blk_count + CW'(1);
                        end
                    end
                end
                default: begin
                    blk_state <= BLK_IDLE;
                    blk_count <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_btpipe_in_buffer.sv
// tb_btpipe_in_buffer
// Self-checking bench for btpipe_in_buffer. A queue-based model tracks the
// words held, the FWFT visibility rule, the flags and the block framing; a
// negedge process compares every output against it each cycle. Directed
// sequences pin the model with hand-computed values, then a randomized
// phase exercises mixed traffic.
module tb_btpipe_in_buffer;

    localparam int WIDTH     = 16;
    localparam int DEPTH     = 256;
    localparam int BLOCK_LEN = 64;

    logic                   clock = 1'b0;
    logic                   reset = 1'b1;
    logic                   clear = 1'b0;
    logic                   ep_write = 1'b0;
    logic                   ep_blockstrobe = 1'b0;
    logic [WIDTH-1:0]       ep_datain = '0;
    logic                   data_ready = 1'b0;
    logic                   ep_ready;
    logic [WIDTH-1:0]       data_out;
    logic                   data_valid;
    logic [$clog2(DEPTH):0] fill_level;
    logic                   overflow;
    logic                   short_block;

    int checks = 0;
    int errors = 0;

    // Behavioural model state.
    logic [WIDTH-1:0] mq[$];
    bit               m_valid;
    bit               m_ready;
    bit               m_overflow;
    bit               m_short;
    bit               m_inblk;
    int               m_count;
    int               m_pushed;
    int               m_size_before;

    // Words the consumer side took, recorded by the driver.
    logic [WIDTH-1:0] seen_q[$];

    btpipe_in_buffer #(
        .WIDTH     (WIDTH),
        .DEPTH     (DEPTH),
        .BLOCK_LEN (BLOCK_LEN)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .clear          (clear),
        .ep_write       (ep_write),
        .ep_blockstrobe (ep_blockstrobe),
        .ep_datain      (ep_datain),
        .ep_ready       (ep_ready),
        .data_out       (data_out),
        .data_valid     (data_valid),
        .data_ready     (data_ready),
        .fill_level     (fill_level),
        .overflow       (overflow),
        .short_block    (short_block)
    );

    always #5 clock = ~clock;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Model: the buffer is an ordered list of held words. A word is visible
    // at the head once it has been held across at least one edge. Fullness
    // is judged on the count before the edge.
    always @(posedge clock or posedge reset) begin
        if (reset) begin
            mq.delete();
            m_valid    = 1'b0;
            m_ready    = 1'b0;
            m_overflow = 1'b0;
            m_short    = 1'b0;
            m_inblk    = 1'b0;
            m_count    = 0;
        end else if (clear) begin
            mq.delete();
            m_valid    = 1'b0;
            m_ready    = (DEPTH >= BLOCK_LEN);
            m_overflow = 1'b0;
            m_short    = 1'b0;
            m_inblk    = 1'b0;
            m_count    = 0;
        end else begin
            m_pushed      = 0;
            m_size_before = mq.size();
            if (m_valid && data_ready) begin
                void'(mq.pop_front());
            end
            if (ep_write) begin
                if (m_size_before < DEPTH) begin
                    mq.push_back(ep_datain);
                    m_pushed = 1;
                end else begin
                    m_overflow = 1'b1;
                end
            end
            m_valid = (mq.size() - m_pushed) > 0;
            m_ready = (DEPTH - mq.size()) >= BLOCK_LEN;
            if (ep_blockstrobe) begin
                if (m_inblk && m_count < BLOCK_LEN) begin
                    m_short = 1'b1;
                end
                m_inblk = 1'b1;
                m_count = 0;
            end else if (m_inblk && ep_write) begin
                m_count++;
                if (m_count >= BLOCK_LEN) begin
                    m_inblk = 1'b0;
                end
            end
        end
    end

    // Per-cycle comparison of every output against the model.
    always @(negedge clock) begin
        if (!reset) begin
            checkOutput("fill_level", 32'(fill_level), 32'(mq.size()));
            checkOutput("data_valid", 32'(data_valid), 32'(m_valid));
            if (m_valid) begin
                checkOutput("data_out", 32'(data_out), 32'(mq[0]));
            end
            checkOutput("ep_ready", 32'(ep_ready), 32'(m_ready));
            checkOutput("overflow", 32'(overflow), 32'(m_overflow));
            checkOutput("short_block", 32'(short_block), 32'(m_short));
        end
    end

    // Drive one cycle of inputs from a negedge, record a word the consumer
    // takes on the coming edge, and return at the following negedge.
    task automatic applyStimulus(input logic w, input logic s, input logic [WIDTH-1:0] d,
                                 input logic r, input logic c);
        ep_write       = w;
        ep_blockstrobe = s;
        ep_datain      = d;
        data_ready     = r;
        clear          = c;
        if (data_valid && r && !c && !reset) begin
            seen_q.push_back(data_out);
        end
        @(negedge clock);
    endtask

    task automatic drainAll(input int budget, input bit toggle);
        int  n = 0;
        logic r = 1'b1;
        while (mq.size() != 0 && n < budget) begin
            applyStimulus(1'b0, 1'b0, '0, r, 1'b0);
            if (toggle) r = ~r;
            n++;
        end
        if (mq.size() != 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL drain_timeout remaining=%0d required=0", mq.size());
        end
    endtask

    initial begin
        int n;
        int written;
        int cyc;
        int bad;
        logic r;
        logic w;

        // Reset state.
        repeat (3) @(negedge clock);
        checkOutput("rst_fill", 32'(fill_level), 0);
        checkOutput("rst_valid", 32'(data_valid), 0);
        checkOutput("rst_data", 32'(data_out), 0);
        checkOutput("rst_ready", 32'(ep_ready), 0);
        checkOutput("rst_overflow", 32'(overflow), 0);
        checkOutput("rst_short", 32'(short_block), 0);
        reset = 1'b0;
        applyStimulus(1'b0, 1'b0, '0, 1'b0, 1'b0);
        checkOutput("ready_after_reset", 32'(ep_ready), 1);

        // Single block, consumer always ready.
        $display("[TB] single block");
        seen_q.delete();
        applyStimulus(1'b0, 1'b1, '0, 1'b1, 1'b0);
        applyStimulus(1'b1, 1'b0, 16'd0, 1'b1, 1'b0);
        checkOutput("fwft_not_yet", 32'(data_valid), 0);
        applyStimulus(1'b1, 1'b0, 16'd1, 1'b1, 1'b0);
        checkOutput("fwft_valid", 32'(data_valid), 1);
        checkOutput("fwft_data", 32'(data_out), 0);
        for (int i = 2; i < 64; i++) applyStimulus(1'b1, 1'b0, WIDTH'(i), 1'b1, 1'b0);
        drainAll(200, 1'b0);
        checkOutput("single_count", 32'(seen_q.size()), 64);
        bad = 0;
        for (int i = 0; i < seen_q.size(); i++) if (seen_q[i] !== WIDTH'(i)) bad++;
        checkOutput("single_order_bad", 32'(bad), 0);
        checkOutput("single_short", 32'(short_block), 0);

        // Backpressure until full, then an overflowing write with a pop.
        $display("[TB] backpressure and full");
        applyStimulus(1'b0, 1'b0, '0, 1'b0, 1'b1);
        seen_q.delete();
        n = 0;
        for (int b = 0; b < 4; b++) begin
            applyStimulus(1'b0, 1'b1, '0, 1'b0, 1'b0);
            for (int i = 0; i < 64; i++) begin
                n++;
                applyStimulus(1'b1, 1'b0, WIDTH'(n - 1), 1'b0, 1'b0);
                if (n == 192) checkOutput("ready_at_192", 32'(ep_ready), 1);
                if (n == 193) checkOutput("ready_drop_193", 32'(ep_ready), 0);
            end
        end
        checkOutput("full_fill", 32'(fill_level), 256);
        checkOutput("full_no_overflow", 32'(overflow), 0);
        checkOutput("full_short", 32'(short_block), 0);
        applyStimulus(1'b1, 1'b0, 16'hBEEF, 1'b1, 1'b0);
        checkOutput("overflow_set", 32'(overflow), 1);
        checkOutput("overflow_fill", 32'(fill_level), 255);
        drainAll(600, 1'b0);
        checkOutput("full_count", 32'(seen_q.size()), 256);
        checkOutput("full_first", 32'(seen_q[0]), 0);
        checkOutput("full_last_intact", 32'(seen_q[255]), 255);
        checkOutput("overflow_sticky", 32'(overflow), 1);

        // Short block.
        $display("[TB] short block");
        applyStimulus(1'b0, 1'b0, '0, 1'b0, 1'b1);
        seen_q.delete();
        applyStimulus(1'b0, 1'b1, '0, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) applyStimulus(1'b1, 1'b0, WIDTH'(100 + i), 1'b0, 1'b0);
        checkOutput("short_before", 32'(short_block), 0);
        applyStimulus(1'b0, 1'b1, '0, 1'b0, 1'b0);
        checkOutput("short_set", 32'(short_block), 1);
        drainAll(100, 1'b0);
        checkOutput("short_count", 32'(seen_q.size()), 10);
        checkOutput("short_first", 32'(seen_q[0]), 100);
        checkOutput("short_last", 32'(seen_q[9]), 109);

        // Long stream through the pointer wrap, consumer toggling.
        $display("[TB] wrap stream");
        applyStimulus(1'b0, 1'b0, '0, 1'b0, 1'b1);
        seen_q.delete();
        written = 0;
        cyc = 0;
        r = 1'b0;
        while (written < 1000 && cyc < 6000) begin
            w = (mq.size() < DEPTH);
            applyStimulus(w, 1'b0, WIDTH'(written), r, 1'b0);
            if (w) written++;
            r = ~r;
            cyc++;
        end
        checkOutput("wrap_written", 32'(written), 1000);
        drainAll(3000, 1'b1);
        checkOutput("wrap_count", 32'(seen_q.size()), 1000);
        bad = 0;
        for (int i = 0; i < seen_q.size(); i++) if (seen_q[i] !== WIDTH'(i)) bad++;
        checkOutput("wrap_order_bad", 32'(bad), 0);
        checkOutput("wrap_fill_zero", 32'(fill_level), 0);
        checkOutput("wrap_no_overflow", 32'(overflow), 0);

        // Clear in the middle of a block, with a same-cycle write.
        $display("[TB] clear mid-block");
        applyStimulus(1'b0, 1'b1, '0, 1'b0, 1'b0);
        for (int i = 0; i < 30; i++) applyStimulus(1'b1, 1'b0, WIDTH'(i), 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b1, '0, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) applyStimulus(1'b1, 1'b0, WIDTH'(i), 1'b0, 1'b0);
        checkOutput("preclear_short", 32'(short_block), 1);
        checkOutput("preclear_fill", 32'(fill_level), 35);
        applyStimulus(1'b1, 1'b0, 16'h5555, 1'b0, 1'b1);
        checkOutput("clear_valid", 32'(data_valid), 0);
        checkOutput("clear_fill", 32'(fill_level), 0);
        checkOutput("clear_short", 32'(short_block), 0);
        checkOutput("clear_overflow", 32'(overflow), 0);

        // Asynchronous reset in the middle of a block.
        $display("[TB] reset mid-block");
        applyStimulus(1'b0, 1'b1, '0, 1'b0, 1'b0);
        for (int i = 0; i < 30; i++) applyStimulus(1'b1, 1'b0, WIDTH'(i), 1'b0, 1'b0);
        ep_write = 1'b0;
        #2 reset = 1'b1;
        #1;
        checkOutput("areset_data", 32'(data_out), 0);
        checkOutput("areset_valid", 32'(data_valid), 0);
        checkOutput("areset_fill", 32'(fill_level), 0);
        checkOutput("areset_ready", 32'(ep_ready), 0);
        checkOutput("areset_overflow", 32'(overflow), 0);
        checkOutput("areset_short", 32'(short_block), 0);
        @(negedge clock);
        reset = 1'b0;
        applyStimulus(1'b0, 1'b0, '0, 1'b0, 1'b0);
        checkOutput("areset_ready_back", 32'(ep_ready), 1);
        applyStimulus(1'b0, 1'b1, '0, 1'b0, 1'b0);
        checkOutput("abandoned_no_short", 32'(short_block), 0);

        // Randomized mixed traffic with varying consumer pressure.
        $display("[TB] random traffic");
        for (int seg = 0; seg < 4; seg++) begin
            for (int i = 0; i < 800; i++) begin
                applyStimulus($urandom_range(0, 99) < 60,
                              $urandom_range(0, 99) < 4,
                              WIDTH'($urandom),
                              $urandom_range(0, 99) < (20 + seg * 25),
                              $urandom_range(0, 399) == 0);
            end
        end
        drainAll(1000, 1'b0);
        checkOutput("random_end_fill", 32'(fill_level), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
